// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution controller:
// branch kinds, AArch64 condition codes, FSM states, NZCV bit positions
// and the condition evaluator used by the resolve stage.
package branch_pkg;

   typedef enum logic [1:0] {
      BR_B     = 2'b00,
      BR_CBZ   = 2'b01,
      BR_BCOND = 2'b10,
      BR_CBNZ  = 2'b11
   } br_kind_e;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'b00,
      ST_WAIT_FLAGS = 2'b01,
      ST_EVAL       = 2'b10,
      ST_RESOLVE    = 2'b11
   } br_state_e;

   // AArch64 condition-code encodings
   localparam logic [3:0] COND_EQ = 4'h0;
   localparam logic [3:0] COND_NE = 4'h1;
   localparam logic [3:0] COND_HS = 4'h2;
   localparam logic [3:0] COND_LO = 4'h3;
   localparam logic [3:0] COND_MI = 4'h4;
   localparam logic [3:0] COND_PL = 4'h5;
   localparam logic [3:0] COND_VS = 4'h6;
   localparam logic [3:0] COND_VC = 4'h7;
   localparam logic [3:0] COND_HI = 4'h8;
   localparam logic [3:0] COND_LS = 4'h9;
   localparam logic [3:0] COND_GE = 4'hA;
   localparam logic [3:0] COND_LT = 4'hB;
   localparam logic [3:0] COND_GT = 4'hC;
   localparam logic [3:0] COND_LE = 4'hD;
   localparam logic [3:0] COND_AL = 4'hE;
   localparam logic [3:0] COND_NV = 4'hF;

   // Bit positions inside the 4-bit {N,Z,C,V} vector
   localparam int NZCV_N = 3;
   localparam int NZCV_Z = 2;
   localparam int NZCV_C = 1;
   localparam int NZCV_V = 0;

   // Returns 1 when condition code i_cond holds for flag vector i_nzcv.
   function automatic logic cond_holds(input logic [3:0] i_cond, input logic [3:0] i_nzcv);
      logic n, z, c, v;
      logic r;
      n = i_nzcv[NZCV_N];
      z = i_nzcv[NZCV_Z];
      c = i_nzcv[NZCV_C];
      v = i_nzcv[NZCV_V];
      case (i_cond)
         COND_EQ: r = z;
         COND_NE: r = ~z;
         COND_HS: r = c;
         COND_LO: r = ~c;
         COND_MI: r = n;
         COND_PL: r = ~n;
         COND_VS: r = v;
         COND_VC: r = ~v;
         COND_HI: r = c & ~z;
         COND_LS: r = ~(c & ~z);
         COND_GE: r = (n == v);
         COND_LT: r = (n != v);
         COND_GT: r = ~z & (n == v);
         COND_LE: r = ~(~z & (n == v));
         COND_AL: r = 1'b1;
         COND_NV: r = 1'b1;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/branch_resolve_ctrl_zero_checker.sv
// Zero detector for the CBZ/CBNZ operand: per-byte OR reduction followed
// by a final NOR, giving a two-level tree the EVAL slot absorbs.
module zero_checker #(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] i_operand,
   output logic             o_is_zero
);

   localparam int NBYTES = WIDTH / 8;

   logic [NBYTES-1:0] w_byte_any;

   for (genvar g = 0; g < NBYTES; g++) begin : g_byte
      assign w_byte_any[g] = |i_operand[g*8 +: 8];
   end

   assign o_is_zero = ~|w_byte_any;

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: accepts one decode-stage branch at a time,
// waits for in-flight flag producers when a B.cond needs them, evaluates
// the decision one cycle later and emits a one-cycle result strobe.
// Also owns the architectural NZCV register.
module branch_resolve_ctrl
   import branch_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flag_we,
   input  logic [3:0]       flags_in,
   input  logic             flag_pending,
   input  logic             br_req,
   input  logic [1:0]       br_kind,
   input  logic [3:0]       br_cond,
   input  logic [WIDTH-1:0] br_operand,
   output logic             br_ready,
   output logic             res_valid,
   output logic             res_taken,
   output logic             stall,
   output logic [3:0]       flags_q
);

   br_state_e        r_state;
   br_state_e        w_next_state;
   br_kind_e         r_kind;
   logic [3:0]       r_cond;
   logic [WIDTH-1:0] r_operand;
   logic [3:0]       r_flags;
   logic             r_br_ready;
   logic             r_res_valid;
   logic             r_res_taken;
   logic             r_stall;
   logic             w_accept;
   logic             w_is_zero;
   logic [3:0]       w_flags_eff;
   logic             w_taken;

   assign w_accept = br_req & r_br_ready;

   // A flag write landing in the EVAL cycle is forwarded so B.cond never
   // resolves against stale NZCV.
   assign w_flags_eff = flag_we ? flags_in : r_flags;

   zero_checker #(.WIDTH(WIDTH)) u_zero_checker (
      .i_operand (r_operand),
      .o_is_zero (w_is_zero)
   );

   // Next-state logic: only a B.cond with an outstanding flag producer waits.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               if ((br_kind_e'(br_kind) == BR_BCOND) && flag_pending && !flag_we) begin
                  w_next_state = ST_WAIT_FLAGS;
               end else begin
                  w_next_state = ST_EVAL;
               end
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_WAIT_FLAGS: begin
            if (flag_we) begin
               w_next_state = ST_EVAL;
            end else begin
               w_next_state = ST_WAIT_FLAGS;
            end
         end
         ST_EVAL:    w_next_state = ST_RESOLVE;
         ST_RESOLVE: w_next_state = ST_IDLE;
         default:    w_next_state = ST_IDLE;
      endcase
   end

   // Branch decision from the captured request, valid in the EVAL cycle.
   always_comb begin
      w_taken = 1'b0;
      case (r_kind)
         BR_B:     w_taken = 1'b1;
         BR_CBZ:   w_taken = w_is_zero;
         BR_CBNZ:  w_taken = ~w_is_zero;
         BR_BCOND: w_taken = cond_holds(r_cond, w_flags_eff);
         default:  w_taken = 1'b0;
      endcase
   end

   // State register and registered handshake/result outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_br_ready  <= 1'b1;
         r_res_valid <= 1'b0;
         r_res_taken <= 1'b0;
         r_stall     <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_br_ready  <= (w_next_state == ST_IDLE);
         r_stall     <= (w_next_state != ST_IDLE);
         r_res_valid <= (r_state == ST_EVAL);
         r_res_taken <= (r_state == ST_EVAL) ? w_taken : 1'b0;
      end
   end

   // Architectural NZCV: loads on every flag write regardless of FSM state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_flags <= 4'b0000;
      end else if (flag_we) begin
         r_flags <= flags_in;
      end
   end

   // Request capture on accept.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_kind    <= BR_B;
         r_cond    <= 4'h0;
         r_operand <= '0;
      end else if (w_accept) begin
         r_kind    <= br_kind_e'(br_kind);
         r_cond    <= br_cond;
         r_operand <= br_operand;
      end
   end

   assign br_ready  = r_br_ready;
   assign res_valid = r_res_valid;
   assign res_taken = r_res_taken;
   assign stall     = r_stall;
   assign flags_q   = r_flags;

endmodule
